// File: rtl/cas_recorder_if.sv
// rtl/cas_recorder_if.sv - SDRAM write-port bundle between the cassette recorder and the shared SDRAM port
interface cas_recorder_if;
  logic        sdram_available_i;
  logic        sdram_ready_i;
  logic        sdram_we_o;
  logic [20:0] sdram_addr_o;
  logic [7:0]  sdram_data_o;

  modport master (
    input  sdram_available_i,
    input  sdram_ready_i,
    output sdram_we_o,
    output sdram_addr_o,
    output sdram_data_o
  );

  modport slave (
    output sdram_available_i,
    output sdram_ready_i,
    input  sdram_we_o,
    input  sdram_addr_o,
    input  sdram_data_o
  );
endinterface

// File: rtl/cas_recorder.sv
// rtl/cas_recorder.sv - SVI328 cassette recorder: FSK half-period decode into bytes written to SDRAM
module cas_recorder #(
  parameter int unsigned HALF_THRESH = 3356,
  parameter int unsigned MAX_HALF    = 8191,
  parameter int unsigned WR_HOLD     = 8,
  parameter logic [20:0] ADDR_INIT   = 21'h0
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ce_i,
  input  logic              record_i,
  input  logic              rewind_i,
  input  logic              tap_i,
  cas_recorder_if.master    sdram,
  output logic [20:0]       len_o,
  output logic [2:0]        status_o
);
  localparam logic [13:0] MAX_HALF_C = 14'(MAX_HALF);
  localparam logic [13:0] THRESH_C   = 14'(HALF_THRESH);
  localparam logic [7:0]  HOLD_LAST  = (WR_HOLD == 0) ? 8'd0 : 8'(WR_HOLD - 1);

  typedef enum logic [2:0] {A_IDLE, A_L1, A_S1, A_S2, A_S3} asm_e;
  typedef enum logic       {W_IDLE, W_HOLD} wr_e;

  logic        tap_s1_q, tap_s2_q, tap_s3_q;
  logic [13:0] hcnt_q, hcnt_d;
  logic        armed_q, armed_d;
  asm_e        asm_q, asm_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        active_q, active_d;
  logic [7:0]  mem_q [2];
  logic [7:0]  mem_d [2];
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        overflow_q, overflow_d, full_q, full_d;
  wr_e         wst_q, wst_d;
  logic [7:0]  hold_q, hold_d;
  logic [20:0] addr_q, addr_d, len_q, len_d;

  logic tap_edge, gap, classify, half_long;
  logic bit_done, bit_val, push, push_ok, grant;
  logic [7:0] byte_val;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tap_s1_q   <= 1'b0;
      tap_s2_q   <= 1'b0;
      tap_s3_q   <= 1'b0;
      hcnt_q     <= '0;
      armed_q    <= 1'b0;
      asm_q      <= A_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      active_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      wst_q      <= W_IDLE;
      hold_q     <= '0;
      addr_q     <= ADDR_INIT;
      len_q      <= '0;
    end else begin
      tap_s1_q   <= tap_i;
      tap_s2_q   <= tap_s1_q;
      tap_s3_q   <= tap_s2_q;
      hcnt_q     <= hcnt_d;
      armed_q    <= armed_d;
      asm_q      <= asm_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      active_q   <= active_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      wst_q      <= wst_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
    end
  end

  always_comb begin
    tap_edge  = tap_s2_q ^ tap_s3_q;
    gap       = (hcnt_q == MAX_HALF_C);
    classify  = tap_edge && record_i && armed_q && !gap;
    half_long = (hcnt_q >= THRESH_C);

    hcnt_d = hcnt_q;
    if (tap_edge)
      hcnt_d = '0;
    else if (ce_i && !gap)
      hcnt_d = hcnt_q + 14'd1;
    // An edge only arms timing; the half it closes is valid only if timing was already armed.
    armed_d = tap_edge ? record_i : (armed_q && record_i && !gap);

    asm_d    = asm_q;
    bit_done = 1'b0;
    bit_val  = 1'b0;
    if (classify) begin
      unique case (asm_q)
        A_IDLE: asm_d = half_long ? A_L1 : A_S1;
        A_L1: begin
          if (half_long) begin
            bit_done = 1'b1;
            asm_d    = A_IDLE;
          end else begin
            asm_d = A_S1;
          end
        end
        A_S1: asm_d = half_long ? A_L1 : A_S2;
        A_S2: asm_d = half_long ? A_L1 : A_S3;
        A_S3: begin
          if (!half_long) begin
            bit_done = 1'b1;
            bit_val  = 1'b1;
            asm_d    = A_IDLE;
          end else begin
            asm_d = A_L1;
          end
        end
        default: asm_d = A_IDLE;
      endcase
    end

    byte_val = {shreg_q[6:0], bit_val};
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    active_d = active_q;
    push     = 1'b0;
    if (bit_done) begin
      shreg_d  = byte_val;
      bitcnt_d = bitcnt_q + 3'd1;
      active_d = 1'b1;
      push     = (bitcnt_q == 3'd7);
    end
    if (!record_i || gap) begin
      asm_d    = A_IDLE;
      bitcnt_d = '0;
      active_d = 1'b0;
    end

    grant   = (wst_q == W_IDLE) && (cnt_q != 2'd0) && sdram.sdram_available_i &&
              sdram.sdram_ready_i && !full_q && !rewind_i;
    push_ok = push && !full_q && (cnt_q != 2'd2);

    overflow_d = overflow_q | (push && !full_q && (cnt_q == 2'd2));
    mem_d      = mem_q;
    if (push_ok)
      mem_d[wr_ptr_q] = byte_val;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ grant;
    cnt_d    = cnt_q + {1'b0, push_ok} - {1'b0, grant};

    full_d = full_q;
    addr_d = addr_q;
    len_d  = len_q;
    wst_d  = wst_q;
    hold_d = hold_q;
    if (grant) begin
      len_d = len_q + 21'd1;
      // The last address latches full instead of wrapping onto the start of the region.
      if (addr_q == 21'h1FFFFF)
        full_d = 1'b1;
      else
        addr_d = addr_q + 21'd1;
      wst_d  = (WR_HOLD == 0) ? W_IDLE : W_HOLD;
      hold_d = HOLD_LAST;
    end else if (wst_q == W_HOLD) begin
      if (hold_q == 8'd0)
        wst_d = W_IDLE;
      else
        hold_d = hold_q - 8'd1;
    end

    if (rewind_i) begin
      asm_d      = A_IDLE;
      shreg_d    = '0;
      bitcnt_d   = '0;
      active_d   = 1'b0;
      mem_d[0]   = '0;
      mem_d[1]   = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      cnt_d      = '0;
      overflow_d = 1'b0;
      full_d     = 1'b0;
      wst_d      = W_IDLE;
      hold_d     = '0;
      addr_d     = ADDR_INIT;
      len_d      = '0;
    end
  end

  assign sdram.sdram_we_o   = grant;
  assign sdram.sdram_addr_o = addr_q;
  assign sdram.sdram_data_o = mem_q[rd_ptr_q];
  assign len_o              = len_q;
  assign status_o           = {overflow_q, full_q, active_q};
endmodule

// File: tb/tb_cas_recorder.sv
// tb/tb_cas_recorder.sv - self-checking bench for cas_recorder with a half-period level decode model
module tb_cas_recorder;
  localparam int S_LEN = 10;
  localparam int L_LEN = 30;

  typedef struct {
    logic [20:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, rst_n2 = 1'b0;
  logic ce = 1'b1, rec = 1'b1, rewind = 1'b0, tap = 1'b0;
  logic avail = 1'b1, ready = 1'b1;
  logic rnd_mode = 1'b0;
  logic [20:0] len1, len2;
  logic [2:0]  st1, st2;
  int cyc = 0;
  int n_vec = 0, n_err = 0;
  int base1 = 0, base2 = 0;
  wr_t w1[$];
  wr_t w2[$];
  bit  hq[$];
  logic [7:0] exp_q[$];

  cas_recorder_if sif1();
  cas_recorder_if sif2();
  assign sif1.sdram_available_i = avail;
  assign sif1.sdram_ready_i     = ready;
  assign sif2.sdram_available_i = avail;
  assign sif2.sdram_ready_i     = ready;

  cas_recorder #(.HALF_THRESH(20), .MAX_HALF(100), .WR_HOLD(2)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .ce_i(ce), .record_i(rec), .rewind_i(rewind),
    .tap_i(tap), .sdram(sif1), .len_o(len1), .status_o(st1));

  cas_recorder #(.HALF_THRESH(20), .MAX_HALF(100), .WR_HOLD(2), .ADDR_INIT(21'h1FFFFE)) dut_top (
    .clk_i(clk), .reset_n_i(rst_n2), .ce_i(ce), .record_i(rec), .rewind_i(rewind),
    .tap_i(tap), .sdram(sif2), .len_o(len2), .status_o(st2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sif1.sdram_we_o === 1'b1) w1.push_back('{sif1.sdram_addr_o, sif1.sdram_data_o, cyc});
    if (sif2.sdram_we_o === 1'b1) w2.push_back('{sif2.sdram_addr_o, sif2.sdram_data_o, cyc});
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t w1_at(input int i);
    wr_t x = '{21'hx, 8'hx, -1};
    if (base1 + i < w1.size()) x = w1[base1 + i];
    return x;
  endfunction

  function automatic wr_t w2_at(input int i);
    wr_t x = '{21'hx, 8'hx, -1};
    if (base2 + i < w2.size()) x = w2[base2 + i];
    return x;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic half(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_mode) begin
        avail = 1'($urandom_range(0, 1));
        ready = 1'($urandom_range(0, 1));
      end
    end
    tap = ~tap;
  endtask

  task automatic lead();
    @(posedge clk);
    #1;
    tap = ~tap;
  endtask

  task automatic send_bit(input logic b);
    if (b) repeat (4) half(S_LEN);
    else   repeat (2) half(L_LEN);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic prep();
    @(posedge clk);
    #1;
    rewind = 1'b1;
    wait_clk(1);
    rewind = 1'b0;
    wait_clk(120);
    base1 = w1.size();
    base2 = w2.size();
  endtask

  // Reference: a half joins the pending run if it matches its type, else restarts it;
  // two longs make a 0, four shorts make a 1, bits pack MSB first into bytes.
  task automatic model_decode();
    bit pend[$];
    bit bits[$];
    logic [7:0] v;
    exp_q.delete();
    foreach (hq[i]) begin
      if (pend.size() != 0 && pend[0] != hq[i]) pend.delete();
      pend.push_back(hq[i]);
      if (hq[i] && pend.size() == 2) begin
        bits.push_back(1'b0);
        pend.delete();
      end else if (!hq[i] && pend.size() == 4) begin
        bits.push_back(1'b1);
        pend.delete();
      end
    end
    for (int b = 0; b + 8 <= bits.size(); b += 8) begin
      v = '0;
      for (int k = 0; k < 8; k++) v = {v[6:0], bits[b + k]};
      exp_q.push_back(v);
    end
  endtask

  initial begin
    wait_clk(3);
    chk("reset.we", {31'd0, sif1.sdram_we_o}, 32'd0);
    chk("reset.addr", {11'd0, sif1.sdram_addr_o}, 32'd0);
    chk("reset.data", {24'd0, sif1.sdram_data_o}, 32'd0);
    chk("reset.len", {11'd0, len1}, 32'd0);
    chk("reset.status", {29'd0, st1}, 32'd0);
    rst_n = 1'b1;

    prep();
    lead();
    send_byte(8'hA5);
    wait_clk(10);
    chk("a5.count", w1.size() - base1, 1);
    chk("a5.addr", {11'd0, w1_at(0).a}, 32'd0);
    chk("a5.data", {24'd0, w1_at(0).d}, 32'hA5);
    chk("a5.len", {11'd0, len1}, 32'd1);
    chk("a5.status", {29'd0, st1}, 32'd1);

    prep();
    avail = 1'b0;
    lead();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    wait_clk(5);
    chk("ovf.held_count", w1.size() - base1, 0);
    chk("ovf.status", {29'd0, st1}, 32'd5);
    avail = 1'b1;
    wait_clk(20);
    chk("ovf.count", w1.size() - base1, 2);
    chk("ovf.d0", {24'd0, w1_at(0).d}, 32'h00);
    chk("ovf.a0", {11'd0, w1_at(0).a}, 32'd0);
    chk("ovf.d1", {24'd0, w1_at(1).d}, 32'hFF);
    chk("ovf.a1", {11'd0, w1_at(1).a}, 32'd1);
    chk("ovf.spacing", w1_at(1).c - w1_at(0).c, 3);
    chk("ovf.sticky", {31'd0, st1[2]}, 32'd1);

    prep();
    lead();
    half(L_LEN);
    half(S_LEN);
    half(L_LEN);
    wait_clk(5);
    chk("glitch.no_bit", {29'd0, st1}, 32'd0);
    half(L_LEN);
    wait_clk(5);
    chk("glitch.bit0", {29'd0, st1}, 32'd1);
    repeat (7) send_bit(1'b1);
    wait_clk(10);
    chk("glitch.count", w1.size() - base1, 1);
    chk("glitch.data", {24'd0, w1_at(0).d}, 32'h7F);

    prep();
    lead();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    wait_clk(150);
    chk("gap.count", w1.size() - base1, 0);
    chk("gap.status", {29'd0, st1}, 32'd0);
    lead();
    send_byte(8'h81);
    wait_clk(10);
    chk("gap.after_count", w1.size() - base1, 1);
    chk("gap.after_data", {24'd0, w1_at(0).d}, 32'h81);
    chk("gap.after_addr", {11'd0, w1_at(0).a}, 32'd0);

    rst_n2 = 1'b1;
    prep();
    lead();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    wait_clk(10);
    chk("full.count", w2.size() - base2, 2);
    chk("full.a0", {11'd0, w2_at(0).a}, 32'h1FFFFE);
    chk("full.d0", {24'd0, w2_at(0).d}, 32'h11);
    chk("full.a1", {11'd0, w2_at(1).a}, 32'h1FFFFF);
    chk("full.d1", {24'd0, w2_at(1).d}, 32'h22);
    chk("full.status", {29'd0, st2}, 32'd3);
    chk("full.len", {11'd0, len2}, 32'd2);
    chk("full.addr_hold", {11'd0, sif2.sdram_addr_o}, 32'h1FFFFF);

    prep();
    lead();
    send_byte(8'h12);
    send_byte(8'h34);
    wait_clk(10);
    chk("rew.len_before", {11'd0, len1}, 32'd2);
    avail = 1'b0;
    send_byte(8'h56);
    wait_clk(10);
    chk("rew.pending", w1.size() - base1, 2);
    @(posedge clk);
    #1;
    rewind = 1'b1;
    avail = 1'b1;
    @(negedge clk);
    chk("rew.no_strobe", {31'd0, sif1.sdram_we_o}, 32'd0);
    @(posedge clk);
    #1;
    rewind = 1'b0;
    chk("rew.len", {11'd0, len1}, 32'd0);
    chk("rew.addr", {11'd0, sif1.sdram_addr_o}, 32'd0);
    chk("rew.status", {29'd0, st1}, 32'd0);
    wait_clk(10);
    chk("rew.no_write", w1.size() - base1, 2);

    for (int r = 0; r < 3; r++) begin
      logic [7:0] rb;
      prep();
      hq.delete();
      for (int b = 0; b < 4; b++) begin
        rb = 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
          if ($urandom_range(0, 9) == 0) hq.push_back(1'($urandom_range(0, 1)));
          if (rb[i]) repeat (4) hq.push_back(1'b0);
          else       repeat (2) hq.push_back(1'b1);
        end
      end
      repeat ($urandom_range(0, 3)) hq.push_back(1'($urandom_range(0, 1)));
      model_decode();
      rnd_mode = 1'b1;
      lead();
      foreach (hq[i]) half(hq[i] ? int'($urandom_range(24, 70)) : int'($urandom_range(6, 17)));
      wait_clk(5);
      rnd_mode = 1'b0;
      avail = 1'b1;
      ready = 1'b1;
      rec = 1'b0;
      wait_clk(40);
      rec = 1'b1;
      chk($sformatf("rnd%0d.count", r), w1.size() - base1, exp_q.size());
      chk($sformatf("rnd%0d.len", r), {11'd0, len1}, exp_q.size());
      foreach (exp_q[i]) begin
        chk($sformatf("rnd%0d.d%0d", r, i), {24'd0, w1_at(i).d}, {24'd0, exp_q[i]});
        chk($sformatf("rnd%0d.a%0d", r, i), {11'd0, w1_at(i).a}, i);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
